enc_spi_seq: RTL
================

ENC_SPI_SEQ -- requirements
Module: enc_spi_seq

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning SCLK half-period in clk_clk cycles (legal 1..255).
REQ-002 clk_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  high only in IDLE; a command transfers on cmd_valid && cmd_ready.
REQ-006 cmd_op  in  3  ENC28J60 opcode.
REQ-007 cmd_addr  in  5  register address/argument.
REQ-008 cmd_wdata  in  8  data byte.
REQ-009 cmd_dummy  in  1  insert one 0x00 byte between command and data (MAC/MII reads).
REQ-010 rsp_valid  out  1  one-cycle pulse at transaction end.
REQ-011 rsp_rdata  out  8  last MISO byte captured.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 enc_spi_SCLK  out  1  SPI clock, mode 0, idles low.
REQ-014 enc_spi_MOSI  out  1  serial data out, MSB first.
REQ-015 enc_spi_SS_n  out  1  chip select, active low.
REQ-016 enc_spi_MISO  in  1  serial data in.

Function
REQ-017 On acceptance, op, addr, wdata and dummy SHALL be latched; later input changes have no effect until the next acceptance.
REQ-018 Frame SHALL be: byte0 = {op,addr}; optional 0x00 dummy; byte1 = wdata. Exception: op==3'b111 (SRC) SHALL send byte0 only, ignoring cmd_dummy.
REQ-019 Bit count N SHALL be 8 (SRC), 16 (normal) or 24 (dummy).
REQ-020 States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> CS_GAP -> IDLE; no other transitions except reset.
REQ-021 IDLE: SS_n=1, SCLK=0, MOSI=0; acceptance moves to CS_SETUP on the next edge.
REQ-022 CS_SETUP: SS_n=0, SCLK=0, MOSI = first bit; lasts CLK_DIV cycles.
REQ-023 SHIFT: each bit lasts 2*CLK_DIV cycles, SCLK low for the first CLK_DIV cycles, high for the second; MOSI changes only at bit-period start (SCLK low).
REQ-024 MISO SHALL be sampled on the clk_clk edge where SCLK goes 0->1, shifted into an 8-bit register MSB first.
REQ-025 After bit N, SCLK returns low and the state moves to CS_HOLD (SS_n=0, CLK_DIV cycles); then CS_GAP (SS_n=1, 2*CLK_DIV cycles).
REQ-026 rsp_valid SHALL pulse for exactly one cycle on the CS_HOLD->CS_GAP transition; rsp_rdata SHALL update in that same cycle to the final 8 sampled bits and hold until the next pulse.
REQ-027 Latency from acceptance edge to rsp_valid high SHALL be (2N+2)*CLK_DIV+1 cycles; cmd_ready SHALL return 2*CLK_DIV cycles after rsp_valid.
REQ-028 cmd_valid while busy SHALL be ignored (no queuing, no error).
REQ-029 Back-to-back commands SHALL always be separated by a CS_GAP of SS_n high.
REQ-030 Bit and divider counters SHALL be 5-bit and 8-bit; no wrap occurs within legal CLK_DIV.

Reset
REQ-031 Asserting reset_reset_n low SHALL immediately, at any state including mid-SHIFT, force IDLE, SS_n=1, SCLK=0, MOSI=0, rsp_valid=0, rsp_rdata=0x00, busy=0, cmd_ready=1.
REQ-032 An interrupted transaction SHALL produce no rsp_valid; first acceptance is possible on the first edge after release.

Verification
REQ-033 CLK_DIV=4, RCR op=000 addr=0x1F, MISO model returns 0xA5 on byte1 -> MOSI 0x1F then wdata, rsp_rdata=0xA5, rsp_valid at cycle 137 after accept.
REQ-034 MII read op=000 addr=0x14 dummy=1, slave drives 0xFF on dummy, 0x3C on data -> 24 SCLK pulses, rsp_rdata=0x3C, latency 201.
REQ-035 SRC op=111 dummy=1 -> exactly 8 SCLK pulses, MOSI 0xFF, latency 73.
REQ-036 cmd_valid held high across two commands -> second accepted only after CS_GAP; SS_n high >= 8 cycles between frames.
REQ-037 Reset asserted at bit 9 of a WCR -> SS_n=1, SCLK=0 asynchronously, no rsp_valid; following command completes normally.
REQ-038 CLK_DIV=1 write 0x5A -> SCLK toggles every cycle, MOSI bits sampled on rising SCLK = 0x5A.

Source files
------------

// File: rtl/enc_spi_seq.sv
// enc_spi_seq -- command sequencer for an ENC28J60 SPI master (mode 0).
//
// Accepts one command (opcode, address, data byte, optional dummy byte). It
// frames the command on the SPI bus and reports the last MISO byte it captured.
//
// Ports:
//   clk_clk, reset_reset_n      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_op/addr/wdata/dummy     command fields, latched on acceptance
//   rsp_valid, rsp_rdata        one-cycle completion pulse, last MISO byte
//   busy                        high whenever not IDLE
//   enc_spi_SCLK/MOSI/SS_n/MISO SPI pins
//
// Parameter CLK_DIV: SCLK half-period in clk_clk cycles (1..255).
module enc_spi_seq #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_dummy,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       enc_spi_SCLK,
  output logic       enc_spi_MOSI,
  output logic       enc_spi_SS_n,
  input  logic       enc_spi_MISO
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] DIV_HOLD = 8'(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_CS_GAP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [4:0]  nbits_q, nbits_d;
  logic        phase_q, phase_d;   // SHIFT: 0 = SCLK low half, 1 = high half
  logic [23:0] tx_q, tx_d;         // MOSI always driven from bit 23
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      nbits_q     <= '0;
      phase_q     <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      nbits_q     <= nbits_d;
      phase_q     <= phase_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    nbits_d     = nbits_q;
    phase_d     = phase_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_CS_SETUP;
          div_d   = '0;
          if (cmd_op == 3'b111) begin
            tx_d    = {cmd_op, cmd_addr, 16'h0000};
            nbits_d = 5'd8;
          end else if (cmd_dummy) begin
            tx_d    = {cmd_op, cmd_addr, 8'h00, cmd_wdata};
            nbits_d = 5'd24;
          end else begin
            tx_d    = {cmd_op, cmd_addr, cmd_wdata, 8'h00};
            nbits_d = 5'd16;
          end
        end
      end

      S_CS_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = S_SHIFT;
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            // SCLK rises on this edge: capture MISO here.
            phase_d = 1'b1;
            rx_d    = {rx_q[6:0], enc_spi_MISO};
          end else begin
            phase_d = 1'b0;
            if (bit_q == nbits_q - 5'd1) begin
              state_d = S_CS_HOLD;
            end else begin
              bit_d = bit_q + 5'd1;
              tx_d  = {tx_q[22:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      // Hold lasts CLK_DIV+1 cycles so acceptance-to-response latency is
      // (2N+2)*CLK_DIV+1 with the response registered on the exit edge.
      S_CS_HOLD: begin
        if (div_q == DIV_HOLD) begin
          state_d     = S_CS_GAP;
          div_d       = '0;
          phase_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = rx_q;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      // Gap counts two CLK_DIV halves so the 8-bit divider never wraps.
      S_CS_GAP: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (phase_q) begin
            state_d = S_IDLE;
            phase_d = 1'b0;
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign enc_spi_SS_n = (state_q == S_IDLE) || (state_q == S_CS_GAP);
  assign enc_spi_SCLK = (state_q == S_SHIFT) && phase_q;
  assign enc_spi_MOSI = ((state_q == S_CS_SETUP) || (state_q == S_SHIFT)) && tx_q[23];

endmodule
